// File: rtl/proc_trace_capture.sv
// Commit-trace recorder: samples regfile writeback and dmem stores for a bounded
// number of cycles and queues one stamped entry per writing cycle for a consumer.
module proc_trace_capture #(
    parameter int CYCLE_LIMIT = 100,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pc,
    input  logic              ctrl_writeEnable,
    input  logic [REG_W-1:0]  ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address_dmem,
    input  logic [DATA_W-1:0] data,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [CNT_W-1:0]  trace_cycle,
    output logic [DATA_W-1:0] trace_pc,
    output logic              trace_rf_we,
    output logic [REG_W-1:0]  trace_rf_rd,
    output logic [DATA_W-1:0] trace_rf_data,
    output logic              trace_mem_we,
    output logic [ADDR_W-1:0] trace_mem_addr,
    output logic [DATA_W-1:0] trace_mem_data,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(CYCLE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  cyc;
        logic [DATA_W-1:0] pc;
        logic              rf_we;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rf_data;
        logic              mem_we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mem_data;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;

    // ---- stage p0: sample the architectural write ports ----
    logic   rf_ev_p0;
    logic   mem_ev_p0;
    logic   push_p0;
    entry_t entry_p0;

    always_comb begin
        rf_ev_p0  = ctrl_writeEnable && (ctrl_writeReg != '0);
        mem_ev_p0 = wren;
        push_p0   = (state == RUN) && (rf_ev_p0 || mem_ev_p0);

        entry_p0          = '0;
        entry_p0.cyc      = cyc_cnt;
        entry_p0.pc       = pc;
        entry_p0.rf_we    = rf_ev_p0;
        entry_p0.rd       = rf_ev_p0 ? ctrl_writeReg : '0;
        entry_p0.rf_data  = rf_ev_p0 ? data_writeReg : '0;
        entry_p0.mem_we   = mem_ev_p0;
        entry_p0.addr     = mem_ev_p0 ? address_dmem : '0;
        entry_p0.mem_data = mem_ev_p0 ? data : '0;
    end

    // ---- stage p1: registered FIFO, head read straight from storage ----
    entry_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             vld_p1;
    logic             full_p1;
    logic             pop_p1;
    logic             accept_p0;
    logic             drop_p0;
    entry_t           head_p1;

    assign vld_p1    = (occ != '0);
    assign full_p1   = (occ == FULL_OCC);
    assign pop_p1    = vld_p1 && trace_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign accept_p0 = push_p0 && (!full_p1 || pop_p1);
    assign drop_p0   = push_p0 && full_p1 && !pop_p1;
    assign head_p1   = vld_p1 ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (accept_p0) begin
            fifo_mem[wr_ptr] <= entry_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (accept_p0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_p1) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept_p0, pop_p1})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Capture control; busy/done are registered together with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        cyc_cnt    <= '0;
                        overflow   <= 1'b0;
                        drop_count <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                    if (drop_p0) begin
                        overflow   <= 1'b1;
                        drop_count <= sat_inc(drop_count);
                    end
                    if (cyc_cnt == LAST_CYC) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vld_p1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign trace_valid    = vld_p1;
    assign trace_cycle    = head_p1.cyc;
    assign trace_pc       = head_p1.pc;
    assign trace_rf_we    = head_p1.rf_we;
    assign trace_rf_rd    = head_p1.rd;
    assign trace_rf_data  = head_p1.rf_data;
    assign trace_mem_we   = head_p1.mem_we;
    assign trace_mem_addr = head_p1.addr;
    assign trace_mem_data = head_p1.mem_data;

endmodule

// File: tb/tb_proc_trace_capture.sv
// Bench for proc_trace_capture: a queue model of the trace FIFO plus table rows
// and hand sequences for overflow, full push/pop, run end, restart and reset.
module tb_proc_trace_capture;

    localparam int LIMIT = 100;
    localparam int DEP   = 4;
    localparam int CW    = 16;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int RW    = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] pc;
    logic          ctrl_writeEnable;
    logic [RW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic          wren;
    logic [AW-1:0] address_dmem;
    logic [DW-1:0] data;
    logic          trace_valid;
    logic          trace_ready;
    logic [CW-1:0] trace_cycle;
    logic [DW-1:0] trace_pc;
    logic          trace_rf_we;
    logic [RW-1:0] trace_rf_rd;
    logic [DW-1:0] trace_rf_data;
    logic          trace_mem_we;
    logic [AW-1:0] trace_mem_addr;
    logic [DW-1:0] trace_mem_data;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    proc_trace_capture #(
        .CYCLE_LIMIT(LIMIT), .DEPTH(DEP), .CNT_W(CW), .ADDR_W(AW), .DATA_W(DW), .REG_W(RW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .pc(pc),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_cycle(trace_cycle), .trace_pc(trace_pc), .trace_rf_we(trace_rf_we),
        .trace_rf_rd(trace_rf_rd), .trace_rf_data(trace_rf_data),
        .trace_mem_we(trace_mem_we), .trace_mem_addr(trace_mem_addr),
        .trace_mem_data(trace_mem_data), .overflow(overflow), .drop_count(drop_count),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [CW-1:0] cyc;
        logic [DW-1:0] pc;
        logic          rf_we;
        logic [RW-1:0] rd;
        logic [DW-1:0] rf_data;
        logic          mem_we;
        logic [AW-1:0] addr;
        logic [DW-1:0] mem_data;
    } ent_t;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;

    typedef struct {
        logic          st;
        logic          we;
        logic [RW-1:0] rd;
        logic [DW-1:0] rdat;
        logic          mw;
        logic [AW-1:0] ad;
        logic [DW-1:0] md;
        logic          rdy;
        logic          e_vld;
        logic [CW-1:0] e_cyc;
        logic          e_rfwe;
        logic [RW-1:0] e_rd;
        logic [DW-1:0] e_rfd;
        logic          e_mwe;
        logic [AW-1:0] e_ad;
        logic [DW-1:0] e_md;
        logic          e_busy;
    } vec_t;

    ent_t sb[$];
    mst_t ms;
    int   mc;
    logic mov;
    int   mdrop;
    int   nvec  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = (sb.size() != 0) ? sb[0] : '0;
        chk("valid", trace_valid, sb.size() != 0);
        chk("cycle", trace_cycle, h.cyc);
        chk("pc", trace_pc, h.pc);
        chk("rf_we", trace_rf_we, h.rf_we);
        chk("rf_rd", trace_rf_rd, h.rd);
        chk("rf_data", trace_rf_data, h.rf_data);
        chk("mem_we", trace_mem_we, h.mem_we);
        chk("mem_addr", trace_mem_addr, h.addr);
        chk("mem_data", trace_mem_data, h.mem_data);
        chk("overflow", overflow, mov);
        chk("drop_count", drop_count, mdrop);
        chk("busy", busy, (ms == M_RUN) || (ms == M_DRAIN));
        chk("done", done, ms == M_DONE);
    endtask

    // Called #1 after a rising edge: check, drive one cycle, advance the model, wait.
    task automatic tick(input logic rst, input logic st, input logic we, input logic [RW-1:0] rd,
                        input logic [DW-1:0] rdat, input logic mw, input logic [AW-1:0] ad,
                        input logic [DW-1:0] md, input logic rdy);
        ent_t e;
        logic pop, push, was_empty;
        check_model();
        reset = rst; start = st; ctrl_writeEnable = we; ctrl_writeReg = rd;
        data_writeReg = rdat; wren = mw; address_dmem = ad; data = md; trace_ready = rdy;
        pc = $urandom;
        was_empty  = (sb.size() == 0);
        pop        = !was_empty && rdy;
        e.cyc      = CW'(mc);
        e.pc       = pc;
        e.rf_we    = we && (rd != '0);
        e.rd       = e.rf_we ? rd : '0;
        e.rf_data  = e.rf_we ? rdat : '0;
        e.mem_we   = mw;
        e.addr     = mw ? ad : '0;
        e.mem_data = mw ? md : '0;
        push       = (ms == M_RUN) && (e.rf_we || mw);
        if (rst) begin
            sb.delete(); ms = M_IDLE; mc = 0; mov = 1'b0; mdrop = 0;
        end else begin
            if (pop) sb.delete(0);
            if (push) begin
                if (sb.size() < DEP) sb.push_back(e);
                else begin
                    mov = 1'b1;
                    if (mdrop < 65535) mdrop++;
                end
            end
            case (ms)
                M_IDLE, M_DONE: if (st) begin ms = M_RUN; mc = 0; mov = 1'b0; mdrop = 0; end
                M_RUN: begin
                    if (mc == LIMIT - 1) ms = M_DRAIN;
                    mc++;
                end
                M_DRAIN: if (was_empty) ms = M_DONE;
                default: ;
            endcase
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   exp_heads[4];
        int   last;
        logic saw_done;

        tbl[0] = '{1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b0, 16'd0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b0, 16'd0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b0, 16'd0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 5'd3, 32'd7, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b1, 16'd2, 1'b1, 5'd3, 32'd7, 1'b0, 12'd0, 32'd0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b0, 16'd0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 5'd5, 32'd9, 1'b1, 12'd12, 32'd40, 1'b1,
                   1'b1, 16'd4, 1'b1, 5'd5, 32'd9, 1'b1, 12'd12, 32'd40, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b0, 16'd0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1,
                   1'b0, 16'd0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1};
        exp_heads = '{8, 9, 10, 13};

        reset = 1'b1; start = 1'b0; pc = '0; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0;
        data_writeReg = '0; wren = 1'b0; address_dmem = '0; data = '0; trace_ready = 1'b0;
        ms = M_IDLE; mc = 0; mov = 1'b0; mdrop = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;

        // Single rf write, dual write, and an r0 write that must not queue anything.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, tbl[i].st, tbl[i].we, tbl[i].rd, tbl[i].rdat, tbl[i].mw, tbl[i].ad,
                 tbl[i].md, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), trace_valid, tbl[i].e_vld);
            chk($sformatf("tbl%0d_cycle", i), trace_cycle, tbl[i].e_cyc);
            chk($sformatf("tbl%0d_rf_we", i), trace_rf_we, tbl[i].e_rfwe);
            chk($sformatf("tbl%0d_rd", i), trace_rf_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_rf_data", i), trace_rf_data, tbl[i].e_rfd);
            chk($sformatf("tbl%0d_mem_we", i), trace_mem_we, tbl[i].e_mwe);
            chk($sformatf("tbl%0d_addr", i), trace_mem_addr, tbl[i].e_ad);
            chk($sformatf("tbl%0d_mem_data", i), trace_mem_data, tbl[i].e_md);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end

        // Six events into a 4-deep FIFO with the consumer stalled (stamps 7..12).
        for (int k = 0; k < 6; k++)
            tick(1'b0, 1'b0, 1'b1, RW'(k + 1), DW'(100 + k), k[0], AW'(k * 4), DW'(200 + k), 1'b0);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", drop_count, 2);
        chk("ovf_head", trace_cycle, 7);

        // Full FIFO, push and pop together at stamp 13.
        tick(1'b0, 1'b0, 1'b1, 5'd9, 32'hAB, 1'b0, 12'd0, 32'd0, 1'b1);
        chk("fpp_drops", drop_count, 2);
        chk("fpp_head", trace_cycle, 8);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("order%0d", k), trace_cycle, exp_heads[k]);
            tick(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1);
        end
        chk("drained", trace_valid, 1'b0);

        // Events every cycle through the end of the run and beyond.
        last = -1;
        saw_done = 1'b0;
        for (int k = 0; k < 200 && !saw_done; k++) begin
            if (trace_valid) last = int'(trace_cycle);
            if (done) saw_done = 1'b1;
            else tick(1'b0, 1'b0, 1'b1, RW'((k % 31) + 1), $urandom, 1'b1, AW'($urandom),
                      $urandom, 1'b1);
        end
        chk("last_stamp", last, 99);
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_ovf", overflow, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 5'd4, 32'd1, 1'b1, 12'd1, 32'd1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 5'd4, 32'd2, 1'b1, 12'd2, 32'd2, 1'b1);

        // Second run restarts stamps and clears status.
        tick(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1);
        chk("rs_done", done, 1'b0);
        chk("rs_busy", busy, 1'b1);
        chk("rs_ovf", overflow, 1'b0);
        chk("rs_drops", drop_count, 0);
        tick(1'b0, 1'b0, 1'b1, 5'd2, 32'd22, 1'b0, 12'd0, 32'd0, 1'b1);
        chk("rs_valid", trace_valid, 1'b1);
        chk("rs_stamp0", trace_cycle, 0);

        // Queue three entries, then reset mid-run (start and ready also high).
        tick(1'b0, 1'b0, 1'b1, 5'd6, 32'd61, 1'b0, 12'd0, 32'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 12'd5, 32'd62, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 5'd7, 32'd63, 1'b1, 12'd6, 32'd64, 1'b0);
        chk("pre_rst_head", trace_cycle, 1);
        tick(1'b1, 1'b1, 1'b1, 5'd8, 32'd65, 1'b0, 12'd0, 32'd0, 1'b1);
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_drops", drop_count, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_cycle", trace_cycle, 0);
        tick(1'b0, 1'b0, 1'b1, 5'd9, 32'd66, 1'b1, 12'd7, 32'd67, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 12'd33, 32'd77, 1'b0);
        chk("fresh_stamp", trace_cycle, 0);
        chk("fresh_mem_we", trace_mem_we, 1'b1);
        chk("fresh_addr", trace_mem_addr, 33);
        tick(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1);
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/proc_trace_capture.md
Name: proc_trace_capture

Overview:
- Parametrised, cycle-limited commit-trace recorder attached beside the pipelined processor inside the skeleton.
- Samples the writeback port (regfile write) and the memory-write port (dmem store) each cycle, together with pc.
- Every cycle with at least one architectural write yields one timestamped entry in an internal FIFO. Entries drain over a valid/ready interface.
- Stops capturing after CYCLE_LIMIT cycles and raises done once the FIFO has drained.

Parameters:
- CYCLE_LIMIT, 100: number of RUN cycles sampled before capture stops (>=1).
- DEPTH, 16: FIFO entries (power of two, >=2).
- CNT_W, 16: width of the cycle stamp and the drop counter.
- ADDR_W, 12: dmem address width.
- DATA_W, 32: data and pc width.
- REG_W, 5: register index width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a capture run from IDLE or DONE
- pc  in  DATA_W  current fetch pc
- ctrl_writeEnable  in  1  regfile write enable
- ctrl_writeReg  in  REG_W  regfile destination
- data_writeReg  in  DATA_W  regfile write data
- wren  in  1  dmem write enable
- address_dmem  in  ADDR_W  dmem address
- data  in  DATA_W  dmem write data
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer accepts head entry
- trace_cycle  out  CNT_W  cycle stamp of head entry
- trace_pc  out  DATA_W  pc of head entry
- trace_rf_we / trace_rf_rd / trace_rf_data  out  1/REG_W/DATA_W  regfile part of head entry
- trace_mem_we / trace_mem_addr / trace_mem_data  out  1/ADDR_W/DATA_W  store part of head entry
- overflow  out  1  sticky; at least one entry was dropped in this run
- drop_count  out  CNT_W  entries dropped, saturating
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE

Behaviour:
- Reset clears state to IDLE, FIFO to empty, cycle counter, drop_count and overflow.
  - All outputs read 0 after reset, including the trace_* fields.
  - reset overrides start and any handshake in the same cycle.
  - Reset during RUN or DRAIN discards all FIFO contents.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE --start--> RUN.
  - RUN --(cycle counter == CYCLE_LIMIT-1, sampled that cycle)--> DRAIN.
  - DRAIN --(FIFO empty)--> DONE. If the FIFO is empty on entry, DRAIN lasts one cycle.
  - DONE --start--> RUN.
  - start in RUN or DRAIN is ignored.
- Entering RUN:
  - clears the cycle counter, overflow and drop_count;
  - does not flush the FIFO. It is already empty when leaving IDLE or DONE.
- Sampling in RUN:
  - Each cycle, the counter value c is the stamp. The counter increments after each RUN cycle.
  - rf_ev = ctrl_writeEnable and ctrl_writeReg != 0. Writes to r0 are ignored.
  - mem_ev = wren.
  - If rf_ev or mem_ev, build one entry {c, pc, rf_ev, rd, rf_data, mem_ev, addr, mem_data}.
  - Fields whose event bit is 0 are stored as zero.
  - If neither event occurs, no entry is pushed.
  - Inputs are ignored outside RUN.
- FIFO:
  - Fully registered. An entry pushed at edge n is visible on trace_valid after that edge, i.e. in cycle n+1. Zero-latency bypass is forbidden.
  - A pop occurs when trace_valid and trace_ready are both high at an edge.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees a slot and the push is accepted.
  - Push when full without a pop: the entry is dropped, overflow is set to 1, and drop_count increments, saturating at all-ones.
  - Pointers wrap modulo DEPTH. Entries are delivered in strict FIFO order.
- Output handshake:
  - trace_* fields hold stable while trace_valid=1 and trace_ready=0.
  - trace_* fields are 0 when trace_valid=0.
- Status outputs:
  - busy = (state==RUN or state==DRAIN).
  - done stays high in DONE until start or reset.

Test Plan:
- Reset, start, then the regfile writes r3=7 in RUN cycle 2 while trace_ready=1.
  - Required: exactly one entry, trace_valid first high in cycle 3, with cycle=2, rf_we=1, rd=3, rf_data=7, mem_we=0, mem fields 0.
- Simultaneous regfile write r5=9 and store addr=12 data=40 in cycle 4.
  - Required: a single entry with both rf_we=1 and mem_we=1 and all fields correct.
  - A write to r0 alone in cycle 5 produces no entry.
- DEPTH=4, trace_ready=0, six event cycles.
  - Required: 4 entries held, overflow=1, drop_count=2.
  - After releasing ready, the entries emerge in order with stamps of the first four events.
- Full FIFO with push and pop in the same cycle.
  - Required: count stays 4, no drop, new entry appended at the tail.
- CYCLE_LIMIT=100, events every cycle, ready held high.
  - Required: last stamp 99; events in cycle 100+ are ignored; busy falls and done rises once empty.
  - A second start clears done, drop_count and overflow, and stamps restart at 0.
- Reset asserted mid-RUN with 3 entries queued.
  - Required: next cycle trace_valid=0, state IDLE, all counters 0; a subsequent start behaves as a fresh run.
